// File: rtl/sort_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sort_loader_pkg: state encodings and length-address helper for the       |
// | bubble-sort loader and core.                      Rev 1.0                |
// +--------------------------------------------------------------------------+
package sort_loader_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_LEN  = 3'd2,
    ST_SORT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // The top RAM word holds the array length; data lives below it.
  function automatic int len_addr_of(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sort_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sort_loader_if: input stream, sort-core control/write port and RAM       |
// | write port of the loader.                         Rev 1.0                |
// +--------------------------------------------------------------------------+
interface sort_loader_if
  import sort_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  logic              sort_rst;
  logic              sort_start;
  logic              sort_finish;
  logic [ADDR_W-1:0] sort_waddr;
  logic [DATA_W-1:0] sort_wdata;
  logic              sort_wen;

  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wen;

  modport slave (
    input  in_valid, in_data, in_last,
    input  sort_finish, sort_waddr, sort_wdata, sort_wen,
    output in_ready, sort_rst, sort_start,
    output mem_waddr, mem_wdata, mem_wen
  );

  modport master (
    output in_valid, in_data, in_last,
    output sort_finish, sort_waddr, sort_wdata, sort_wen,
    input  in_ready, sort_rst, sort_start,
    input  mem_waddr, mem_wdata, mem_wen
  );

endinterface
`default_nettype wire

// File: rtl/sort_loader_wport_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sort_wport_mux: RAM write-port mux between loader and sort core, with a  |
// | registered select so the core path is glitch-free.  Rev 1.0             |
// +--------------------------------------------------------------------------+
module sort_wport_mux
  import sort_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_core_next,
  input  logic [ADDR_W-1:0] ld_waddr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_wen,
  input  logic [ADDR_W-1:0] core_waddr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              core_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen
);

  logic r_sel_core;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_core <= 1'b0;
    end else begin
      r_sel_core <= sel_core_next;
    end
  end

  assign mem_waddr = r_sel_core ? core_waddr : ld_waddr;
  assign mem_wdata = r_sel_core ? core_wdata : ld_wdata;
  assign mem_wen   = r_sel_core ? core_wen   : ld_wen;

endmodule
`default_nettype wire

// File: rtl/sort_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sort_loader: streams words into the sort RAM, writes the length word,    |
// | then runs the sort core until Finish.             Rev 1.0                |
// +--------------------------------------------------------------------------+
module sort_loader
  import sort_loader_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LEN_ADDR = len_addr_of(ADDR_W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_req,
  sort_loader_if.slave   bus,
  output logic           busy,
  output logic           done,
  output logic           overflow
);

  localparam logic [ADDR_W-1:0] c_len_addr  = ADDR_W'(LEN_ADDR);
  localparam logic [ADDR_W-1:0] c_last_data = ADDR_W'(LEN_ADDR - 1);
  localparam logic [ADDR_W-1:0] c_min_sort  = ADDR_W'(2);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_next;
  logic              r_overflow;
  logic              w_overflow_next;

  logic              w_in_ready;
  logic              w_sort_rst;
  logic              w_sort_start;
  logic              w_done;
  logic              w_ld_wen;
  logic [ADDR_W-1:0] w_ld_waddr;
  logic [DATA_W-1:0] w_ld_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_overflow <= w_overflow_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_overflow_next = r_overflow;
    w_in_ready      = 1'b0;
    w_sort_rst      = 1'b1;
    w_sort_start    = 1'b0;
    w_done          = 1'b0;
    w_ld_wen        = 1'b0;
    w_ld_waddr      = r_cnt;
    w_ld_wdata      = bus.in_data;

    case (r_state)
      ST_IDLE: begin
        if (load_req) begin
          w_cnt_next      = '0;
          w_overflow_next = 1'b0;
          w_state_next    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_ld_wen   = 1'b1;
          w_cnt_next = r_cnt + 1'b1;
          if (bus.in_last) begin
            w_state_next = ST_LEN;
          end else if (r_cnt == c_last_data) begin
            // Data region is full: truncate the stream here.
            w_overflow_next = 1'b1;
            w_state_next    = ST_LEN;
          end
        end
      end
      ST_LEN: begin
        w_ld_wen     = 1'b1;
        w_ld_waddr   = c_len_addr;
        w_ld_wdata   = DATA_W'(r_cnt);
        // The core cannot handle fewer than two elements, and they are sorted anyway.
        w_state_next = (r_cnt < c_min_sort) ? ST_DONE : ST_SORT;
      end
      ST_SORT: begin
        w_sort_rst   = 1'b0;
        w_sort_start = 1'b1;
        if (bus.sort_finish) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.sort_rst   = w_sort_rst;
  assign bus.sort_start = w_sort_start;
  assign busy           = (r_state != ST_IDLE);
  assign done           = w_done;
  assign overflow       = r_overflow;

  sort_wport_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wport_mux (
    .clk           (clk),
    .rst           (rst),
    .sel_core_next (w_state_next == ST_SORT),
    .ld_waddr      (w_ld_waddr),
    .ld_wdata      (w_ld_wdata),
    .ld_wen        (w_ld_wen),
    .core_waddr    (bus.sort_waddr),
    .core_wdata    (bus.sort_wdata),
    .core_wen      (bus.sort_wen),
    .mem_waddr     (bus.mem_waddr),
    .mem_wdata     (bus.mem_wdata),
    .mem_wen       (bus.mem_wen)
  );

endmodule
`default_nettype wire
